tile_fetch_sched: RTL and testbench

- Scheduler that owns the single-port tile-map RAM. It shares that RAM between the pixel pipeline and a host update port.
- For each visible 16x16 cell it fetches the sprite byte (orientation[7:5], bitmap[3:0]) and delivers it aligned with the RGB stream.
- Downstream, the sprite-address generator consumes sprite_o and RGBStr_o directly.
- Host reads and writes are slotted into RAM cycles the display does not need.

---
 rtl/tile_fetch_sched.sv | 110 +++++++++++
 tb/tb_tile_fetch_sched.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_fetch_sched.sv
// tile_fetch_sched: owns the single-port tile-map RAM and shares it between
// the pixel pipeline and a host port. Each RAM cycle is one slot.
//
//   px_clk, reset_n          clock, async active-low reset
//   RGBStr_i / RGBStr_o      pixel stream in, same stream delayed 2 cycles
//   sprite_o                 sprite byte for the pixel currently on RGBStr_o
//   map_addr/_we/_wdata/_rdata  tile-map RAM port (1-cycle read latency)
//   host_req/_we/_addr/_wdata   host request, held until host_gnt
//   host_gnt                 pulse: request taken at the previous edge
//   host_rdata/_rvalid       read return, two edges after the request
//
// The display owns every slot in which a pixel sits on a cell boundary
// (X[3:0]==0) inside the map. Any other slot goes to the host if it asks.
module tile_fetch_sched #(
  parameter int MAP_COLS = 40,
  parameter int MAP_ROWS = 30,
  parameter int MAP_AW   = 11
) (
  input  logic              px_clk,
  input  logic              reset_n,
  input  logic [25:0]       RGBStr_i,
  output logic [25:0]       RGBStr_o,
  output logic [7:0]        sprite_o,
  output logic [MAP_AW-1:0] map_addr,
  output logic              map_we,
  output logic [7:0]        map_wdata,
  input  logic [7:0]        map_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [MAP_AW-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic              host_gnt,
  output logic [7:0]        host_rdata,
  output logic              host_rvalid
);
  typedef enum logic [1:0] {IDLE, DISP, HOST_RD, HOST_WR} slot_e;

  // Stage 0 decode: X = RGBStr_i[22:13], Y = RGBStr_i[12:3], visible = [0]
  logic [5:0]        tx, ty;
  logic              in_map, fetch;
  logic [MAP_AW-1:0] disp_addr;

  assign tx        = RGBStr_i[22:17];
  assign ty        = RGBStr_i[12:7];
  assign in_map    = RGBStr_i[0] && (32'(tx) < MAP_COLS) && (32'(ty) < MAP_ROWS);
  assign fetch     = in_map && (RGBStr_i[16:13] == 4'd0);
  assign disp_addr = MAP_AW'(32'(ty) * MAP_COLS + 32'(tx));

  // Slot FSM: slot_q describes the RAM access issued in the current cycle
  slot_e slot_q;

  always_ff @(posedge px_clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q    <= IDLE;
      map_addr  <= '0;
      map_we    <= 1'b0;
      map_wdata <= '0;
      host_gnt  <= 1'b0;
    end else begin
      map_we   <= 1'b0;
      host_gnt <= 1'b0;
      if (fetch) begin
        slot_q   <= DISP;
        map_addr <= disp_addr;
      end else if (host_req) begin
        slot_q    <= host_we ? HOST_WR : HOST_RD;
        map_addr  <= host_addr;
        map_we    <= host_we;
        map_wdata <= host_wdata;
        host_gnt  <= 1'b1;
      end else begin
        // map_addr deliberately holds to avoid needless address toggling
        slot_q <= IDLE;
      end
    end
  end

  // Stage 2: the RAM answers for slot2_q in this cycle
  slot_e       slot2_q;
  logic [25:0] rgb1_q, rgb2_q;
  logic        show1_q, show2_q;
  logic [7:0]  hold_q;

  always_ff @(posedge px_clk or negedge reset_n) begin
    if (!reset_n) begin
      slot2_q <= IDLE;
      rgb1_q  <= '0;
      rgb2_q  <= '0;
      show1_q <= 1'b0;
      show2_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      slot2_q <= slot_q;
      rgb1_q  <= RGBStr_i;
      rgb2_q  <= rgb1_q;
      show1_q <= in_map;
      show2_q <= show1_q;
      // hold serves the remaining pixels of the cell just fetched
      if (slot2_q == DISP) hold_q <= map_rdata;
    end
  end

  assign RGBStr_o    = rgb2_q;
  // The first pixel of a cell takes the RAM data directly (bypass)
  assign sprite_o    = (slot2_q == DISP) ? map_rdata :
                       show2_q           ? hold_q    : 8'h00;
  assign host_rvalid = (slot2_q == HOST_RD);
  assign host_rdata  = host_rvalid ? map_rdata : 8'h00;

endmodule

// File: tb/tb_tile_fetch_sched.sv
module tb_tile_fetch_sched;
  localparam int AW = 11;

  logic          px_clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [25:0]   RGBStr_i = '0;
  logic [25:0]   RGBStr_o;
  logic [7:0]    sprite_o;
  logic [AW-1:0] map_addr;
  logic          map_we;
  logic [7:0]    map_wdata;
  logic [7:0]    map_rdata;
  logic          host_req = 1'b0;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [7:0]    host_wdata = '0;
  logic          host_gnt;
  logic [7:0]    host_rdata;
  logic          host_rvalid;

  always #5 px_clk = ~px_clk;

  tile_fetch_sched #(.MAP_COLS(40), .MAP_ROWS(30), .MAP_AW(AW)) dut (
    .px_clk(px_clk), .reset_n(reset_n),
    .RGBStr_i(RGBStr_i), .RGBStr_o(RGBStr_o), .sprite_o(sprite_o),
    .map_addr(map_addr), .map_we(map_we), .map_wdata(map_wdata), .map_rdata(map_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid)
  );

  // Tile-map RAM: synchronous, 1-cycle read latency
  logic [7:0] ram [2048];
  always @(posedge px_clk) begin
    map_rdata <= ram[map_addr];
    if (map_we) ram[map_addr] = map_wdata;
  end

  int checks = 0, passes = 0, cyc = 0;

  // Reference model: map contents, last fetched sprite, expected outputs per cycle
  logic [7:0]    mref [2048];
  logic [7:0]    held;
  logic [AW-1:0] last_addr;
  bit            last_grant;
  logic [25:0]   e_rgb [8];
  logic [7:0]    e_spr [8], e_rd [8], e_wd [8];
  bit            e_rv [8], e_gnt [8], e_we [8];
  logic [AW-1:0] e_addr [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic logic [25:0] pix(input int x, input int y, input bit v);
    logic [25:0] p;
    p = 26'($urandom);
    p[22:13] = 10'(x);
    p[12:3]  = 10'(y);
    p[0]     = v;
    return p;
  endfunction

  // Decide what the current inputs should produce one and two cycles later
  task automatic model_cycle();
    int x, y, tx, ty, a, n1, n2;
    bit vis, inmap;
    n1 = (cyc + 1) % 8;
    n2 = (cyc + 2) % 8;
    x = int'(RGBStr_i[22:13]);
    y = int'(RGBStr_i[12:3]);
    vis = RGBStr_i[0];
    tx = x / 16;
    ty = y / 16;
    inmap = vis && tx < 40 && ty < 30;
    e_rgb[n2] = RGBStr_i;
    e_rv[n2] = 0; e_rd[n2] = 8'h00;
    e_gnt[n1] = 0; e_we[n1] = 0; e_wd[n1] = 8'h00;
    last_grant = 0;
    if (inmap && (x % 16 == 0)) begin
      a = ty * 40 + tx;
      e_addr[n1] = AW'(a);
      last_addr = AW'(a);
      held = mref[a];
      e_spr[n2] = held;
    end else begin
      e_spr[n2] = inmap ? held : 8'h00;
      if (host_req) begin
        last_grant = 1;
        e_gnt[n1] = 1; e_we[n1] = host_we; e_addr[n1] = host_addr; e_wd[n1] = host_wdata;
        last_addr = host_addr;
        if (host_we) mref[host_addr] = host_wdata;
        else begin e_rv[n2] = 1; e_rd[n2] = mref[host_addr]; end
      end else begin
        e_addr[n1] = last_addr;
      end
    end
  endtask

  task automatic check_cycle();
    int i;
    i = cyc % 8;
    chk("RGBStr_o", 32'(RGBStr_o), 32'(e_rgb[i]));
    chk("sprite_o", 32'(sprite_o), 32'(e_spr[i]));
    chk("host_gnt", 32'(host_gnt), 32'(e_gnt[i]));
    chk("map_we", 32'(map_we), 32'(e_we[i]));
    chk("map_addr", 32'(map_addr), 32'(e_addr[i]));
    if (e_we[i]) chk("map_wdata", 32'(map_wdata), 32'(e_wd[i]));
    chk("host_rvalid", 32'(host_rvalid), 32'(e_rv[i]));
    if (e_rv[i]) chk("host_rdata", 32'(host_rdata), 32'(e_rd[i]));
  endtask

  task automatic step();
    model_cycle();
    @(posedge px_clk);
    #1;
    cyc++;
    check_cycle();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_rgb", 32'(RGBStr_o), 0);
    chk("rst_sprite", 32'(sprite_o), 0);
    chk("rst_map_addr", 32'(map_addr), 0);
    chk("rst_strobes", {29'd0, map_we, host_gnt, host_rvalid}, 0);
    chk("rst_map_wdata", 32'(map_wdata), 0);
    chk("rst_host_rdata", 32'(host_rdata), 0);
    @(posedge px_clk);
    #1;
    chk("rst_no_rvalid", 32'(host_rvalid), 0);
    chk("rst_no_gnt", 32'(host_gnt), 0);
    reset_n = 1'b1;
    cyc = 0; held = 8'h00; last_addr = '0; last_grant = 0;
    for (int i = 0; i < 8; i++) begin
      e_rgb[i] = '0; e_spr[i] = '0; e_rd[i] = '0; e_wd[i] = '0;
      e_rv[i] = 0; e_gnt[i] = 0; e_we[i] = 0; e_addr[i] = '0;
    end
    check_cycle();
  endtask

  typedef struct {
    int            x, y;
    bit            vis;
    bit            exp_gnt;
    logic [AW-1:0] exp_addr;
  } vec_t;

  initial begin
    vec_t vt [12];
    logic [25:0] line_in [48];
    int x, y, seg;
    bit v;

    vt[0]  = '{0,    35,   1, 0, 11'd80};
    vt[1]  = '{16,   35,   1, 0, 11'd81};
    vt[2]  = '{32,   35,   1, 0, 11'd82};
    vt[3]  = '{1,    35,   1, 1, 11'd2047};
    vt[4]  = '{0,    35,   0, 1, 11'd2047};
    vt[5]  = '{640,  0,    1, 1, 11'd2047};
    vt[6]  = '{624,  0,    1, 0, 11'd39};
    vt[7]  = '{0,    480,  1, 1, 11'd2047};
    vt[8]  = '{624,  464,  1, 0, 11'd1199};
    vt[9]  = '{1008, 0,    1, 1, 11'd2047};
    vt[10] = '{0,    1023, 1, 1, 11'd2047};
    vt[11] = '{16,   16,   1, 0, 11'd41};

    for (int i = 0; i < 2048; i++) begin
      mref[i] = 8'($urandom);
      ram[i] = mref[i];
    end
    for (int k = 0; k < 3; k++) begin
      mref[80 + k] = 8'h20 + 8'(k);
      ram[80 + k] = mref[80 + k];
    end

    #1;
    do_reset();

    // Decode table: a host read of 2047 competes with each pixel
    foreach (vt[i]) begin
      RGBStr_i = pix(vt[i].x, vt[i].y, vt[i].vis);
      host_req = 1; host_we = 0; host_addr = 11'd2047;
      step();
      chk("tbl_gnt", 32'(host_gnt), 32'(vt[i].exp_gnt));
      chk("tbl_addr", 32'(map_addr), 32'(vt[i].exp_addr));
      RGBStr_i = pix(0, 0, 0); host_req = 0;
      step();
      step();
    end

    // Visible line Y=35, host write to 5 arrives with X=16
    for (int k = 0; k < 50; k++) begin
      RGBStr_i = (k < 48) ? pix(k, 35, 1) : pix(0, 0, 0);
      if (k < 48) line_in[k] = RGBStr_i;
      host_req = (k == 16 || k == 17);
      host_we = 1; host_addr = 11'd5; host_wdata = 8'hA3;
      step();
      if (k >= 1 && k <= 48) begin
        chk("line_sprite", 32'(sprite_o), 32'(8'h20 + 8'((k - 1) / 16)));
        chk("line_rgb", 32'(RGBStr_o), 32'(line_in[k - 1]));
      end
      if (k == 0 || k == 16 || k == 32) begin
        chk("line_map_addr", 32'(map_addr), 80 + k / 16);
        chk("line_map_we", 32'(map_we), 0);
      end
      if (k == 16) chk("line_no_gnt", 32'(host_gnt), 0);
      if (k == 17) begin
        chk("wr_gnt", 32'(host_gnt), 1);
        chk("wr_we", 32'(map_we), 1);
        chk("wr_addr", 32'(map_addr), 5);
        chk("wr_data", 32'(map_wdata), 32'h A3);
      end
    end

    // Host read of 5 in blanking
    RGBStr_i = pix(100, 35, 0); host_req = 1; host_we = 0; host_addr = 11'd5;
    step();
    chk("rd_gnt", 32'(host_gnt), 1);
    host_req = 0;
    step();
    chk("rd_rvalid", 32'(host_rvalid), 1);
    chk("rd_rdata", 32'(host_rdata), 32'h A3);
    step();

    // 8 back-to-back writes then 8 back-to-back reads in blanking
    RGBStr_i = pix(0, 500, 0);
    for (int i = 0; i < 8; i++) begin
      host_req = 1; host_we = 1; host_addr = AW'(200 + i); host_wdata = 8'h5A ^ 8'(i * 37);
      step();
      chk("b2b_gnt", 32'(host_gnt), 1);
      chk("b2b_we", 32'(map_we), 1);
      chk("b2b_addr", 32'(map_addr), 200 + i);
    end
    for (int i = 0; i < 9; i++) begin
      host_req = (i < 8); host_we = 0; host_addr = AW'(200 + i);
      step();
      if (i >= 1) begin
        chk("b2b_rvalid", 32'(host_rvalid), 1);
        chk("b2b_rdata", 32'(host_rdata), 32'(8'h5A ^ 8'((i - 1) * 37)));
      end
    end
    host_req = 0;
    step();

    // Reset while a read is in flight, host_req still high
    RGBStr_i = pix(301, 40, 1); host_req = 1; host_we = 0; host_addr = 11'd5;
    step();
    chk("pre_rst_gnt", 32'(host_gnt), 1);
    do_reset();
    step();
    chk("post_rst_gnt", 32'(host_gnt), 1);
    host_req = 0;
    step();
    step();

    // Random streams and host traffic
    x = 0; y = 0; seg = 0; v = 0;
    for (int n = 0; n < 3000; n++) begin
      if (seg == 0) begin
        y = $urandom_range(0, 520);
        x = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 700) : 16 * $urandom_range(0, 42);
        v = ($urandom_range(0, 3) != 0);
        seg = $urandom_range(8, 96);
      end
      RGBStr_i = pix(x, y, v);
      x = (x + 1) % 1024;
      seg--;
      if (last_grant || !host_req) begin
        host_req = ($urandom_range(0, 2) == 0);
        host_we = $urandom_range(0, 1);
        host_addr = AW'($urandom_range(0, 1279));
        host_wdata = 8'($urandom);
      end
      step();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
